// File: rtl/dmem_arbiter_if.sv
// Host loader bus for dmem_arbiter.
// host_lock exists only when DMEM_ARB_HOST_LOCK_EN is defined.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
`ifdef DMEM_ARB_HOST_LOCK_EN
  logic              host_lock;

  modport master (
    output host_valid, host_we, host_addr, host_wdata, host_lock,
    input  host_ready, host_rvalid, host_rdata
  );
  modport slave (
    input  host_valid, host_we, host_addr, host_wdata, host_lock,
    output host_ready, host_rvalid, host_rdata
  );
`else
  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );
  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Data memory arbiter between the SIMD processor and the host loader.
// The processor has fixed priority; a starvation counter forces a host slot
// after STARVE_MAX blocked cycles. Defining DMEM_ARB_HOST_LOCK_EN adds a
// host_lock input giving the host exclusive ownership.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int VEC_W      = 256,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_src_sel,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [VEC_W-1:0]  cpu_wdata_b,
  output logic              cpu_stall,
  dmem_arbiter_if.slave     host,
  output logic              mem_we,
  output logic              mem_src_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [VEC_W-1:0]  mem_wdata_b,
  input  logic [DATA_W-1:0] mem_q_a
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt;
  logic       rd_pend;
  logic       sel_host;
  logic       lock_act;

`ifdef DMEM_ARB_HOST_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t state;

  // Lock applies only while registered LOCKED and host_lock is still high,
  // so arbitration resumes in the very cycle host_lock falls.
  assign lock_act = (state == LOCKED) && host.host_lock;

  // Lock FSM: follows host_lock with one cycle of entry latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
    end else begin
      case (state)
        ARB:     state <= host.host_lock ? LOCKED : ARB;
        LOCKED:  state <= host.host_lock ? LOCKED : ARB;
        default: state <= ARB;
      endcase
    end
  end
`else
  assign lock_act = 1'b0;
`endif

  // Grant, stall and memory mux; all gated low while reset is asserted.
  // A stalled processor never commits a write, which only matters while locked.
  always_comb begin
    sel_host        = reset && host.host_valid &&
                      (lock_act || !cpu_req || (starve_cnt == STARVE_LIM));
    cpu_stall       = reset && cpu_req && (sel_host || lock_act);
    host.host_ready = sel_host;
    if (sel_host) begin
      mem_we      = host.host_we;
      mem_src_sel = 1'b0;
      mem_addr    = host.host_addr;
      mem_wdata   = host.host_wdata;
      mem_wdata_b = '0;
    end else begin
      mem_we      = reset && cpu_req && cpu_we && !cpu_stall;
      mem_src_sel = cpu_src_sel;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
      mem_wdata_b = cpu_wdata_b;
    end
    host.host_rvalid = rd_pend;
    host.host_rdata  = rd_pend ? mem_q_a : '0;
  end

  // Starvation counter and one-cycle host read tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= sel_host && !host.host_we;
      if (lock_act || sel_host || !host.host_valid) begin
        starve_cnt <= '0;
      end else if (cpu_req && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural model predicts grants and
// memory contents; a negedge monitor compares outputs and pops read data.
module tb_dmem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 16;
  localparam int VEC_W      = 256;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              cpu_req, cpu_we, cpu_src_sel, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, mem_wdata, mem_q_a;
  logic [VEC_W-1:0]  cpu_wdata_b, mem_wdata_b;
  logic              mem_we, mem_src_sel;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hif ();

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VEC_W(VEC_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_src_sel(cpu_src_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wdata_b(cpu_wdata_b),
    .cpu_stall(cpu_stall), .host(hif.slave),
    .mem_we(mem_we), .mem_src_sel(mem_src_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wdata_b(mem_wdata_b), .mem_q_a(mem_q_a)
  );

  // Behavioural dmem port A: word-indexed, one-cycle read latency
  logic [15:0] dmem [0:255] = '{default: '0};
  always @(posedge clk) begin
    if (mem_we && !mem_src_sel) dmem[mem_addr[8:1]] <= mem_wdata;
    mem_q_a <= dmem[mem_addr[8:1]];
  end

  // Reference model state
  logic [15:0] gold [0:255] = '{default: '0};
  logic [15:0] rq [$];
  int  waited = 0;
  bit  lk_state = 1'b0;
  bit  chk_en = 1'b0;
  int  n_tests = 0;
  int  n_fail = 0;

  // Expectations for the cycle currently driven
  logic              e_ready, e_stall, e_we, e_src;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [VEC_W-1:0]  e_b;
  logic              obs_ready, obs_stall;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, predict outputs, then commit the model at the edge
  task automatic drive(input logic cr, input logic cw, input logic cs,
                       input logic [31:0] ca, input logic [15:0] cd,
                       input logic [255:0] cb, input logic hv, input logic hw,
                       input logic [31:0] ha, input logic [15:0] hd, input logic lk);
    bit eff, g;
`ifndef DMEM_ARB_HOST_LOCK_EN
    lk = 1'b0;
`endif
    cpu_req = cr; cpu_we = cw; cpu_src_sel = cs; cpu_addr = ca;
    cpu_wdata = cd; cpu_wdata_b = cb;
    hif.host_valid = hv; hif.host_we = hw; hif.host_addr = ha; hif.host_wdata = hd;
`ifdef DMEM_ARB_HOST_LOCK_EN
    hif.host_lock = lk;
`endif
    eff = lk_state && lk;
    g   = hv && (eff || !cr || waited >= STARVE_MAX);
    e_ready = g;
    e_stall = cr && (g || eff);
    if (g) begin
      e_we = hw; e_src = 1'b0; e_addr = ha; e_wdata = hd; e_b = '0;
    end else begin
      e_we = cr && cw && !e_stall; e_src = cs; e_addr = ca; e_wdata = cd; e_b = cb;
    end
    @(posedge clk);
    if (g && hw) gold[ha[8:1]] = hd;
    if (g && !hw) rq.push_back(gold[ha[8:1]]);
    if (!g && e_we && !cs) gold[ca[8:1]] = cd;
    if (eff || g || !hv) waited = 0;
    else if (waited < STARVE_MAX) waited++;
    lk_state = lk;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  // Count blocked cycles of a host read held against continuous cpu_req
  task automatic starve_run(input string name, input logic [31:0] ha);
    int blocked, stalls;
    blocked = 0; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 32'h40, 0, '0, 1, 0, ha, 0, 0);
      if (obs_stall) stalls++;
      if (obs_ready) break;
      blocked++;
    end
    chk({name, "_wait"}, blocked, STARVE_MAX);
    chk({name, "_stalls"}, stalls, 1);
  endtask

  // Monitor: per-cycle output checks and scoreboard pop on host_rvalid
  always @(negedge clk) begin
    obs_ready = hif.host_ready;
    obs_stall = cpu_stall;
    if (chk_en) begin
      chk("host_ready", hif.host_ready, e_ready);
      chk("cpu_stall", cpu_stall, e_stall);
      chk("mem_we", mem_we, e_we);
      chk("mem_src_sel", mem_src_sel, e_src);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_wdata_b", mem_wdata_b, e_b);
      if (rq.size() > 0) begin
        chk("host_rvalid", hif.host_rvalid, 1'b1);
        chk("host_rdata", hif.host_rdata, rq.pop_front());
      end else begin
        chk("host_rvalid", hif.host_rvalid, 1'b0);
      end
    end
  end

  initial begin
    logic [255:0] vec;
    bit lkr;
    // Reset held with both requesters active
    cpu_req = 1; cpu_we = 1; cpu_src_sel = 0; cpu_addr = 0; cpu_wdata = 16'h1111;
    cpu_wdata_b = '0;
    hif.host_valid = 1; hif.host_we = 0; hif.host_addr = 0; hif.host_wdata = 0;
`ifdef DMEM_ARB_HOST_LOCK_EN
    hif.host_lock = 1;
`endif
    #22;
    chk("rst_host_ready", hif.host_ready, 1'b0);
    chk("rst_cpu_stall", cpu_stall, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_host_rvalid", hif.host_rvalid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // Idle processor: host write then read back
    drive(0, 0, 0, 0, 0, '0, 1, 1, 32'h10, 16'hBEEF, 0);
    chk("idle_wr_ready", obs_ready, 1'b1);
    drive(0, 0, 0, 0, 0, '0, 1, 0, 32'h10, 0, 0);
    chk("idle_rd_ready", obs_ready, 1'b1);
    idle(2);

    // Forced grant after STARVE_MAX blocked cycles
    drive(0, 0, 0, 0, 0, '0, 1, 1, 32'h20, 16'h1234, 0);
    starve_run("starve", 32'h20);
    idle(1);

    // Processor vector write with host idle
    vec = {8{$urandom()}};
    drive(1, 1, 1, 32'h30, 16'h5555, vec, 0, 0, 0, 0, 0);
    idle(1);

    // Host gives up at count 5, then must wait the full window again
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 32'h40, 0, '0, 1, 0, 32'h10, 0, 0);
    drive(1, 0, 0, 32'h40, 0, '0, 0, 0, 0, 0, 0);
    starve_run("drop", 32'h10);
    idle(1);

    // Reset one cycle after a host read is accepted
    drive(0, 0, 0, 0, 0, '0, 1, 0, 32'h10, 0, 0);
    chk_en = 1'b0;
    reset = 1'b0;
    rq.delete();
    waited = 0;
    lk_state = 1'b0;
    #1;
    chk("midrst_rvalid", hif.host_rvalid, 1'b0);
    chk("midrst_ready", hif.host_ready, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1'b1;
    starve_run("post_rst", 32'h20);
    idle(1);

`ifdef DMEM_ARB_HOST_LOCK_EN
    // Lock: host owns memory while the processor keeps requesting
    drive(1, 0, 0, 32'h40, 0, '0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      drive(1, 1, 0, 32'h40, 16'h7777, '0, 1, 1, 32'(2 * i), 16'hA000 + 16'(i), 1);
    drive(1, 1, 0, 32'h40, 16'h7777, '0, 0, 0, 0, 0, 1);
    chk("lock_idle_stall", obs_stall, 1'b1);
    drive(1, 0, 0, 32'h40, 0, '0, 1, 1, 32'h8, 16'h9999, 0);
    chk("unlock_resume", obs_stall, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, '0, 1, 0, 32'(2 * i), 0, 0);
    idle(1);
`endif

    // Randomized traffic
    lkr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) lkr = !lkr;
      vec = {8{$urandom()}};
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            32'($urandom_range(0, 15)) << 1, 16'($urandom()), vec,
            $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 15)) << 1, 16'($urandom()), lkr);
    end
    idle(3);
    chk("queue_drained", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory between the SIMD processor and an external host loader, which preloads and dumps images in 16-bit words. The processor has fixed priority. A starvation counter guarantees the host a slot. An optional lock mode gives the host exclusive ownership during bulk transfers. The block sits between `simd_processor` and `dmem` in the top level and drives the memory's `memwrite`, `src_sel`, address and write-data inputs.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 16, scalar (port A) data width
- `VEC_W`, 256, vector (port B) data width
- `STARVE_MAX`, 8, consecutive blocked host cycles before a forced host grant (1..255)
- `clk` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-low
- `cpu_req` in 1: processor memory access this cycle
- `cpu_we` in 1: processor write
- `cpu_src_sel` in 1: 0 selects scalar port A, 1 selects vector port B write source
- `cpu_addr` in `ADDR_W`: processor address
- `cpu_wdata` in `DATA_W`: processor scalar write data
- `cpu_wdata_b` in `VEC_W`: processor vector write data
- `cpu_stall` out 1: processor must hold its request and PC this cycle
- `host_valid` in 1: host request
- `host_we` in 1: host write (0 = read)
- `host_addr` in `ADDR_W`: host address
- `host_wdata` in `DATA_W`: host write data
- `host_ready` out 1: host request accepted this cycle
- `host_rvalid` out 1: host read data valid
- `host_rdata` out `DATA_W`: host read data
- `mem_we`, `mem_src_sel` out 1: to dmem
- `mem_addr` out `ADDR_W`: to dmem
- `mem_wdata` out `DATA_W`: to dmem
- `mem_wdata_b` out `VEC_W`: to dmem
- `mem_q_a` in `DATA_W`: dmem port A read data, valid 1 cycle after address

## Operation
- Registered state: `starve_cnt` (8 bits), `rd_pend` (1 bit), and, when configured, FSM state.
- Host grant, combinational: `sel_host = host_valid && (!cpu_req || starve_cnt == STARVE_MAX)`.
- `host_ready = sel_host`.
- `cpu_stall = cpu_req && sel_host`.
- Memory mux when `sel_host` is high:
  - `mem_addr = host_addr`, `mem_wdata = host_wdata`, `mem_we = host_we`.
  - `mem_src_sel = 0`, `mem_wdata_b = 0`. The host never uses port B.
- Memory mux otherwise: processor fields pass through, and `mem_we = cpu_req && cpu_we`.
- `starve_cnt` update:
  - Cleared when `sel_host` is high or `host_valid` is low.
  - Otherwise, when `host_valid && cpu_req`, increments, saturating at `STARVE_MAX`.
- `rd_pend` is set on a cycle where `sel_host && !host_we`.
- `host_rvalid = rd_pend`, and `host_rdata` equals `mem_q_a` while `rd_pend` is high.
- Processor reads on port A are unaffected by arbitration. A processor read is issued only when it is not stalled.
- Simultaneous host write and processor vector write: the processor wins unless `starve_cnt == STARVE_MAX`. On a forced grant, the processor write is deferred one cycle through `cpu_stall`.
- Reset mid-transfer: `rd_pend` drops immediately and any outstanding host read is lost. The host must reissue it.

## Timing
- Reset values: `starve_cnt = 0`, `rd_pend = 0`, state `ARB`.
- Outputs during reset: `host_rvalid = 0`, `mem_we = 0`, `cpu_stall = 0`, `host_ready = 0`.
- Grant and mux are same-cycle. Writes commit on the rising edge of the accept cycle.
- Host read latency is exactly 1 cycle from accept to `host_rvalid`. Back-to-back host reads give `host_rvalid` on consecutive cycles.
- Worst-case host wait under continuous `cpu_req` is `STARVE_MAX` blocked cycles, with the grant on cycle `STARVE_MAX + 1`.
- Forced grant stalls the processor for exactly 1 cycle. The counter restarts at 0 afterwards.

## Configuration
- Macro: `DMEM_ARB_HOST_LOCK_EN`.
- Defined: adds input `host_lock` (1 bit) and a two-state FSM.
  - `ARB`: normal arbitration as above. Moves to `LOCKED` when `host_lock` is high.
  - `LOCKED`: `sel_host = host_valid`. `cpu_stall = cpu_req` every cycle, including cycles with `host_valid` low. `starve_cnt` is held at 0.
  - `LOCKED` returns to `ARB` on the first cycle with `host_lock` low. Arbitration resumes that same cycle.
  - A pending read completes normally across the transition.
- Undefined: no `host_lock` port and no FSM. Arbitration is fixed priority plus starvation counter only.

## Test plan
- Idle processor, host writes `0xBEEF` to address 0x10, then reads 0x10 → `host_ready` high both cycles; `host_rvalid` high one cycle after the read with `host_rdata = 0xBEEF`; `cpu_stall` stays 0.
- `STARVE_MAX = 8`, `cpu_req` held high, host read of 0x20 held valid → `host_ready` low for 8 cycles and high on the 9th; `cpu_stall` is high for exactly that cycle; `starve_cnt` returns to 0.
- Processor vector write (`cpu_src_sel = 1`) with host idle → `mem_src_sel = 1` and `mem_wdata_b = cpu_wdata_b`; no stall.
- Host read accepted, then `reset` driven low the next cycle → `host_rvalid = 0` immediately; counter at 0 after release.
- `DMEM_ARB_HOST_LOCK_EN`: `host_lock = 1` with `cpu_req = 1` and four host writes to 0x0..0x6 → `cpu_stall` high through the lock; all four words written; processor resumes the cycle `host_lock` falls.
- Host drops `host_valid` at `starve_cnt = 5` → counter clears to 0; the next host request waits the full 8 cycles.
